// File: rtl/pair_pipe.sv
// pair_pipe: elastic DEPTH-stage delay pipeline for {a, b} records with
// valid/ready backpressure, bubble collapsing, flush, occupancy and a sticky a==b check.
module pair_pipe #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2,
  parameter bit CHECK_EQ = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_b,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       eq_err,
  output logic [WIDTH-1:0]           eq_err_a
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] v_next;
  logic [WIDTH-1:0] a_q   [DEPTH];
  logic [WIDTH-1:0] b_q   [DEPTH];
  logic [WIDTH-1:0] src_a [DEPTH];
  logic [WIDTH-1:0] src_b [DEPTH];
  logic             room;
  logic             accept;
  logic             out_fire;

  // A full stage advances when some stage below it is empty or the sink takes the head;
  // walking from the tail avoids a bit-wise combinational loop through adv.
  always_comb begin
    room = out_ready;
    adv  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = v[k] && room;
      room   = room || !v[k];
    end
    in_ready = !flush && room;
  end

  assign accept   = in_valid && in_ready;
  assign out_fire = v[DEPTH-1] && out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign load[k]  = accept;
      assign src_a[k] = in_a;
      assign src_b[k] = in_b;
    end else begin : g_body
      assign load[k]  = adv[k-1];
      assign src_a[k] = a_q[k-1];
      assign src_b[k] = b_q[k-1];
    end
    assign v_next[k] = load[k] || (v[k] && !adv[k]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v        <= '0;
      count    <= '0;
      eq_err   <= 1'b0;
      eq_err_a <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      v <= flush ? '0 : v_next;
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          a_q[k] <= src_a[k];
          b_q[k] <= src_b[k];
        end
      end
      if (flush)
        count <= '0;
      else if (accept && !out_fire)
        count <= count + CW'(1);
      else if (!accept && out_fire)
        count <= count - CW'(1);
      // Only the first offending record is captured.
      if (CHECK_EQ && accept && (in_a == in_b) && !eq_err) begin
        eq_err   <= 1'b1;
        eq_err_a <= in_a;
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_a     = a_q[DEPTH-1];
  assign out_b     = b_q[DEPTH-1];

endmodule

// File: tb/tb_pair_pipe.sv
// tb_pair_pipe: directed self-checking bench for pair_pipe, using a DEPTH=2 checked
// instance and a DEPTH=4 instance with the equality check disabled.
module tb_pair_pipe;
  localparam int W = 16;

  logic clock;
  logic reset;

  logic         d2_flush, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_eq_err;
  logic [W-1:0] d2_in_a, d2_in_b, d2_out_a, d2_out_b, d2_eq_err_a;
  logic [1:0]   d2_count;

  logic         d4_flush, d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready, d4_eq_err;
  logic [W-1:0] d4_in_a, d4_in_b, d4_out_a, d4_out_b, d4_eq_err_a;
  logic [2:0]   d4_count;

  int checks   = 0;
  int failures = 0;

  pair_pipe #(.WIDTH(W), .DEPTH(2), .CHECK_EQ(1'b1)) dut2 (
    .clock(clock), .reset(reset), .flush(d2_flush),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_a(d2_in_a), .in_b(d2_in_b),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_a(d2_out_a), .out_b(d2_out_b),
    .count(d2_count), .eq_err(d2_eq_err), .eq_err_a(d2_eq_err_a)
  );

  pair_pipe #(.WIDTH(W), .DEPTH(4), .CHECK_EQ(1'b0)) dut4 (
    .clock(clock), .reset(reset), .flush(d4_flush),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_a(d4_in_a), .in_b(d4_in_b),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_a(d4_out_a), .out_b(d4_out_b),
    .count(d4_count), .eq_err(d4_eq_err), .eq_err_a(d4_eq_err_a)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (d2_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_d2_in_ready: got %0b expected 1", d2_in_ready); end
    checks++; if (d2_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_d2_out_valid: got %0b expected 0", d2_out_valid); end
    checks++; if (d2_out_a !== 16'h0 || d2_out_b !== 16'h0) begin failures++; $display("[TB] FAIL reset_d2_out_ab: got %0h/%0h expected 0/0", d2_out_a, d2_out_b); end
    checks++; if (d2_count !== 2'd0) begin failures++; $display("[TB] FAIL reset_d2_count: got %0d expected 0", d2_count); end
    checks++; if (d2_eq_err !== 1'b0 || d2_eq_err_a !== 16'h0) begin failures++; $display("[TB] FAIL reset_d2_eq: got %0b/%0h expected 0/0", d2_eq_err, d2_eq_err_a); end
    checks++; if (d4_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_d4_in_ready: got %0b expected 1", d4_in_ready); end
    checks++; if (d4_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_d4_out_valid: got %0b expected 0", d4_out_valid); end
    checks++; if (d4_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_d4_count: got %0d expected 0", d4_count); end
  endtask

  task automatic test_stream();
    logic [W-1:0] exp_a;
    d2_out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      d2_in_valid = 1'b1;
      d2_in_a     = W'(i);
      d2_in_b     = W'(i + 100);
      #1;
      checks++; if (d2_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stream_in_ready[%0d]: got %0b expected 1", i, d2_in_ready); end
      tick();
      if (i == 1) begin
        checks++; if (d2_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_first_out_valid: got %0b expected 0", d2_out_valid); end
        checks++; if (d2_count !== 2'd1) begin failures++; $display("[TB] FAIL stream_first_count: got %0d expected 1", d2_count); end
      end else begin
        exp_a = W'(i - 1);
        checks++; if (d2_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stream_out_valid[%0d]: got %0b expected 1", i, d2_out_valid); end
        checks++; if (d2_out_a !== exp_a) begin failures++; $display("[TB] FAIL stream_out_a[%0d]: got %0d expected %0d", i, d2_out_a, exp_a); end
        checks++; if (d2_out_b !== exp_a + 16'd100) begin failures++; $display("[TB] FAIL stream_out_b[%0d]: got %0d expected %0d", i, d2_out_b, exp_a + 16'd100); end
        checks++; if (d2_count !== 2'd2) begin failures++; $display("[TB] FAIL stream_count[%0d]: got %0d expected 2", i, d2_count); end
      end
    end
    d2_in_valid = 1'b0;
    tick();
    checks++; if (d2_out_valid !== 1'b1 || d2_out_a !== 16'd5) begin failures++; $display("[TB] FAIL stream_last: got v=%0b a=%0d expected v=1 a=5", d2_out_valid, d2_out_a); end
    checks++; if (d2_count !== 2'd1) begin failures++; $display("[TB] FAIL stream_drain_count: got %0d expected 1", d2_count); end
    tick();
    checks++; if (d2_out_valid !== 1'b0 || d2_count !== 2'd0) begin failures++; $display("[TB] FAIL stream_empty: got v=%0b count=%0d expected v=0 count=0", d2_out_valid, d2_count); end
    checks++; if (d2_eq_err !== 1'b0) begin failures++; $display("[TB] FAIL stream_eq_err: got %0b expected 0", d2_eq_err); end
  endtask

  task automatic test_backpressure();
    d4_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d4_in_valid = 1'b1;
      d4_in_a     = W'(10 + i);
      d4_in_b     = W'(10 + i);
      tick();
    end
    checks++; if (d4_count !== 3'd4) begin failures++; $display("[TB] FAIL bp_full_count: got %0d expected 4", d4_count); end
    checks++; if (d4_out_valid !== 1'b1 || d4_out_a !== 16'd10) begin failures++; $display("[TB] FAIL bp_head: got v=%0b a=%0d expected v=1 a=10", d4_out_valid, d4_out_a); end
    d4_in_a = 16'd14;
    d4_in_b = 16'd14;
    #1;
    checks++; if (d4_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_full_in_ready: got %0b expected 0", d4_in_ready); end
    d4_out_ready = 1'b1;
    #1;
    checks++; if (d4_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_drain_in_ready: got %0b expected 1", d4_in_ready); end
    tick();
    d4_in_valid  = 1'b0;
    d4_out_ready = 1'b0;
    #1;
    checks++; if (d4_count !== 3'd4) begin failures++; $display("[TB] FAIL bp_swap_count: got %0d expected 4", d4_count); end
    checks++; if (d4_out_a !== 16'd11) begin failures++; $display("[TB] FAIL bp_swap_head: got %0d expected 11", d4_out_a); end
    d4_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (d4_out_valid !== 1'b1 || d4_out_a !== W'(12 + i)) begin failures++; $display("[TB] FAIL bp_order[%0d]: got v=%0b a=%0d expected v=1 a=%0d", i, d4_out_valid, d4_out_a, 12 + i); end
      checks++; if (d4_count !== 3'(3 - i)) begin failures++; $display("[TB] FAIL bp_drain_count[%0d]: got %0d expected %0d", i, d4_count, 3 - i); end
    end
    tick();
    checks++; if (d4_out_valid !== 1'b0 || d4_count !== 3'd0) begin failures++; $display("[TB] FAIL bp_empty: got v=%0b count=%0d expected v=0 count=0", d4_out_valid, d4_count); end
    d4_out_ready = 1'b0;
  endtask

  task automatic test_bubble();
    d4_out_ready = 1'b0;
    d4_in_valid  = 1'b1;
    d4_in_a      = 16'd7;
    d4_in_b      = 16'd7;
    tick();
    d4_in_valid = 1'b0;
    tick();
    tick();
    d4_in_valid = 1'b1;
    d4_in_a     = 16'd8;
    d4_in_b     = 16'd8;
    tick();
    d4_in_valid = 1'b0;
    checks++; if (d4_out_valid !== 1'b1 || d4_out_a !== 16'd7) begin failures++; $display("[TB] FAIL bubble_head: got v=%0b a=%0d expected v=1 a=7", d4_out_valid, d4_out_a); end
    tick();
    tick();
    checks++; if (d4_count !== 3'd2) begin failures++; $display("[TB] FAIL bubble_count: got %0d expected 2", d4_count); end
    d4_out_ready = 1'b1;
    tick();
    checks++; if (d4_out_valid !== 1'b1 || d4_out_a !== 16'd8) begin failures++; $display("[TB] FAIL bubble_adjacent: got v=%0b a=%0d expected v=1 a=8", d4_out_valid, d4_out_a); end
    checks++; if (d4_count !== 3'd1) begin failures++; $display("[TB] FAIL bubble_after_count: got %0d expected 1", d4_count); end
    tick();
    checks++; if (d4_out_valid !== 1'b0 || d4_count !== 3'd0) begin failures++; $display("[TB] FAIL bubble_empty: got v=%0b count=%0d expected v=0 count=0", d4_out_valid, d4_count); end
    d4_out_ready = 1'b0;
  endtask

  task automatic test_flush();
    d4_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d4_in_valid = 1'b1;
      d4_in_a     = W'(20 + i);
      d4_in_b     = W'(20 + i);
      tick();
    end
    checks++; if (d4_count !== 3'd3) begin failures++; $display("[TB] FAIL flush_pre_count: got %0d expected 3", d4_count); end
    d4_flush = 1'b1;
    d4_in_a  = 16'd23;
    d4_in_b  = 16'd23;
    #1;
    checks++; if (d4_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_in_ready: got %0b expected 0", d4_in_ready); end
    tick();
    d4_flush = 1'b0;
    checks++; if (d4_count !== 3'd0 || d4_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_cleared: got count=%0d v=%0b expected count=0 v=0", d4_count, d4_out_valid); end
    d4_out_ready = 1'b1;
    tick();
    d4_in_valid = 1'b0;
    checks++; if (d4_count !== 3'd1 || d4_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_reaccept: got count=%0d v=%0b expected count=1 v=0", d4_count, d4_out_valid); end
    for (int j = 1; j <= 3; j++) begin
      tick();
      checks++; if (d4_out_valid !== (j == 3)) begin failures++; $display("[TB] FAIL flush_latency[%0d]: got v=%0b expected %0b", j, d4_out_valid, (j == 3)); end
    end
    checks++; if (d4_out_a !== 16'd23) begin failures++; $display("[TB] FAIL flush_new_data: got %0d expected 23", d4_out_a); end
    tick();
    checks++; if (d4_out_valid !== 1'b0 || d4_count !== 3'd0) begin failures++; $display("[TB] FAIL flush_drained: got v=%0b count=%0d expected v=0 count=0", d4_out_valid, d4_count); end
    d4_out_ready = 1'b0;
  endtask

  task automatic test_eq_check();
    d2_out_ready = 1'b1;
    checks++; if (d2_eq_err !== 1'b0) begin failures++; $display("[TB] FAIL eq_before: got %0b expected 0", d2_eq_err); end
    d2_in_valid = 1'b1;
    d2_in_a     = 16'h0055;
    d2_in_b     = 16'h0055;
    tick();
    checks++; if (d2_eq_err !== 1'b1) begin failures++; $display("[TB] FAIL eq_set: got %0b expected 1", d2_eq_err); end
    checks++; if (d2_eq_err_a !== 16'h0055) begin failures++; $display("[TB] FAIL eq_capture: got %0h expected 55", d2_eq_err_a); end
    d2_in_a = 16'h0066;
    d2_in_b = 16'h0066;
    tick();
    d2_in_valid = 1'b0;
    checks++; if (d2_eq_err_a !== 16'h0055) begin failures++; $display("[TB] FAIL eq_no_overwrite: got %0h expected 55", d2_eq_err_a); end
    d2_flush = 1'b1;
    tick();
    d2_flush = 1'b0;
    checks++; if (d2_eq_err !== 1'b1 || d2_eq_err_a !== 16'h0055) begin failures++; $display("[TB] FAIL eq_after_flush: got %0b/%0h expected 1/55", d2_eq_err, d2_eq_err_a); end
    checks++; if (d2_count !== 2'd0) begin failures++; $display("[TB] FAIL eq_flush_count: got %0d expected 0", d2_count); end
    checks++; if (d4_eq_err !== 1'b0 || d4_eq_err_a !== 16'h0) begin failures++; $display("[TB] FAIL eq_disabled: got %0b/%0h expected 0/0", d4_eq_err, d4_eq_err_a); end
  endtask

  task automatic test_reset_mid();
    d2_out_ready = 1'b0;
    d2_in_valid  = 1'b1;
    d2_in_a      = 16'h0030;
    d2_in_b      = 16'h0031;
    tick();
    d2_in_a = 16'h0032;
    d2_in_b = 16'h0033;
    tick();
    checks++; if (d2_count !== 2'd2 || d2_out_a !== 16'h0030) begin failures++; $display("[TB] FAIL midrst_pre: got count=%0d a=%0h expected count=2 a=30", d2_count, d2_out_a); end
    reset        = 1'b1;
    d2_in_a      = 16'h0034;
    d2_in_b      = 16'h0035;
    d2_out_ready = 1'b1;
    tick();
    reset       = 1'b0;
    d2_in_valid = 1'b0;
    checks++; if (d2_count !== 2'd0 || d2_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_state: got count=%0d v=%0b expected count=0 v=0", d2_count, d2_out_valid); end
    checks++; if (d2_eq_err !== 1'b0 || d2_eq_err_a !== 16'h0) begin failures++; $display("[TB] FAIL midrst_eq: got %0b/%0h expected 0/0", d2_eq_err, d2_eq_err_a); end
    checks++; if (d2_out_a !== 16'h0) begin failures++; $display("[TB] FAIL midrst_out_a: got %0h expected 0", d2_out_a); end
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if (d2_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_emit[%0d]: got %0b expected 0", j, d2_out_valid); end
    end
  endtask

  initial begin
    reset        = 1'b1;
    d2_flush     = 1'b0;
    d2_in_valid  = 1'b0;
    d2_in_a      = '0;
    d2_in_b      = '0;
    d2_out_ready = 1'b0;
    d4_flush     = 1'b0;
    d4_in_valid  = 1'b0;
    d4_in_a      = '0;
    d4_in_b      = '0;
    d4_out_ready = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_eq_check();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
